// File: rtl/interrupt_acknowledge_master_8259a.sv
`timescale 1ns/1ps
// CPU-side 8259A interrupt-acknowledge initiator: drives the INTA# pulse train and captures the vector/CALL bytes.
// Latency: trigger to vector_valid = N*INTA_LOW_CYCLES + (N-1)*INTA_GAP_CYCLES + 1 cycles (+2 with INT_SYNC_EN).
// Backpressure: the result is held in PRESENT until vector_ready; int_request is only looked at in IDLE.
// Optional macro INT_SYNC_EN: two-flop synchronizer on int_request.
module interrupt_acknowledge_master_8259a #(
  parameter int unsigned INTA_LOW_CYCLES = 2,
  parameter int unsigned INTA_GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        int_request,
  input  logic        cpu_int_enable,
  input  logic        mode_8086,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [7:0]  vector_type,
  output logic [15:0] call_address,
  output logic        call_opcode_error
);

  typedef enum logic [1:0] {IDLE, PULSE_LOW, PULSE_GAP, PRESENT} state_t;

  localparam logic [7:0] LOW_LAST = 8'(INTA_LOW_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(INTA_GAP_CYCLES - 1);
  localparam logic [7:0] CALL_OP  = 8'hCD;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  pulse_idx_q;
  logic        mode_q;
  logic [7:0]  byte0_q;
  logic [7:0]  byte1_q;
  logic        inta_n_q;
  logic        busy_q;
  logic        valid_q;
  logic [7:0]  vtype_q;
  logic [15:0] caddr_q;
  logic        cerr_q;
  logic        int_req_d;
  logic        last_pulse;

`ifdef INT_SYNC_EN
  logic [1:0] int_sync_q;

  // Two-flop synchronizer for an INT pin coming from another clock domain.
  always_ff @(posedge clock) begin
    if (reset) int_sync_q <= 2'b00;
    else       int_sync_q <= {int_sync_q[0], int_request};
  end

  assign int_req_d = int_sync_q[1];
`else
  assign int_req_d = int_request;
`endif

  // 8086 ends after pulse index 1, 8080/85 after pulse index 2.
  assign last_pulse = mode_q ? (pulse_idx_q == 2'd1) : (pulse_idx_q == 2'd2);

  // Acknowledge sequencer with registered INTA#, status and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      pulse_idx_q <= 2'd0;
      mode_q      <= 1'b0;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      inta_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      vtype_q     <= 8'h00;
      caddr_q     <= 16'h0000;
      cerr_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (int_req_d && cpu_int_enable) begin
            state_q     <= PULSE_LOW;
            mode_q      <= mode_8086;
            pulse_idx_q <= 2'd0;
            cnt_q       <= 8'd0;
            inta_n_q    <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        PULSE_LOW: begin
          if (cnt_q == LOW_LAST) begin
            cnt_q    <= 8'd0;
            inta_n_q <= 1'b1;
            case (pulse_idx_q)
              2'd0:    byte0_q <= data_bus_in;
              2'd1:    byte1_q <= data_bus_in;
              default: ;
            endcase
            if (last_pulse) begin
              state_q <= PRESENT;
              valid_q <= 1'b1;
              if (mode_q) begin
                // Pulse-1 byte is a dummy in 8086 mode; pulse 2 carries the vector.
                vtype_q <= data_bus_in;
                caddr_q <= 16'h0000;
                cerr_q  <= 1'b0;
              end else begin
                vtype_q <= byte0_q;
                caddr_q <= {data_bus_in, byte1_q};
                cerr_q  <= (byte0_q != CALL_OP);
              end
            end else begin
              state_q <= PULSE_GAP;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PULSE_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q       <= 8'd0;
            pulse_idx_q <= pulse_idx_q + 2'd1;
            inta_n_q    <= 1'b0;
            state_q     <= PULSE_LOW;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PRESENT: begin
          if (vector_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign interrupt_acknowledge_n = inta_n_q;
  assign busy                    = busy_q;
  assign vector_valid            = valid_q;
  assign vector_type             = vtype_q;
  assign call_address            = caddr_q;
  assign call_opcode_error       = cerr_q;

endmodule

// File: tb/tb_interrupt_acknowledge_master_8259a.sv
`timescale 1ns/1ps
// Bench for interrupt_acknowledge_master_8259a: directed acknowledge sequences,
// a timeline-based reference model checked every cycle, plus literal expectations.
module tb_interrupt_acknowledge_master_8259a;

  localparam int L = 2;
  localparam int G = 2;
  localparam int P = L + G;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        int_request = 1'b0;
  logic        cpu_int_enable = 1'b0;
  logic        mode_8086 = 1'b1;
  logic [7:0]  data_bus_in = 8'h00;
  logic        interrupt_acknowledge_n;
  logic        busy;
  logic        vector_valid;
  logic        vector_ready = 1'b0;
  logic [7:0]  vector_type;
  logic [15:0] call_address;
  logic        call_opcode_error;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  interrupt_acknowledge_master_8259a #(
    .INTA_LOW_CYCLES(L),
    .INTA_GAP_CYCLES(G)
  ) dut (
    .clock(clock),
    .reset(reset),
    .int_request(int_request),
    .cpu_int_enable(cpu_int_enable),
    .mode_8086(mode_8086),
    .data_bus_in(data_bus_in),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .busy(busy),
    .vector_valid(vector_valid),
    .vector_ready(vector_ready),
    .vector_type(vector_type),
    .call_address(call_address),
    .call_opcode_error(call_opcode_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the edge count since the trigger.
  logic       m_act = 1'b0, m_pres = 1'b0, m_mode = 1'b0;
  int         m_k = 0;
  logic [7:0] m_b [0:2];
  logic       e_inta = 1'b1, e_busy = 1'b0, e_valid = 1'b0, e_err = 1'b0;
  logic [7:0] e_vt = 8'h00;
  logic [15:0] e_ca = 16'h0000;

  function automatic int ntot(input logic m);
    return m ? (2 * L + G) : (3 * L + 2 * G);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_act = 1'b0; m_pres = 1'b0;
      e_inta = 1'b1; e_busy = 1'b0; e_valid = 1'b0;
      e_vt = 8'h00; e_ca = 16'h0000; e_err = 1'b0;
    end else if (m_pres) begin
      if (vector_ready) begin
        m_pres = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
      end
    end else if (m_act) begin
      m_k++;
      if (((m_k - 1) % P) == L - 1) m_b[(m_k - 1) / P] = data_bus_in;
      if (m_k == ntot(m_mode)) begin
        m_act = 1'b0; m_pres = 1'b1; e_valid = 1'b1; e_inta = 1'b1;
        if (m_mode) begin
          e_vt = m_b[1]; e_ca = 16'h0000; e_err = 1'b0;
        end else begin
          e_vt = m_b[0]; e_ca = {m_b[2], m_b[1]}; e_err = (m_b[0] != 8'hCD);
        end
      end else begin
        e_inta = ((m_k % P) < L) ? 1'b0 : 1'b1;
      end
    end else if (int_request && cpu_int_enable) begin
      m_act = 1'b1; m_k = 0; m_mode = mode_8086;
      e_busy = 1'b1; e_inta = 1'b0;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmp_inta_n",  32'(interrupt_acknowledge_n), 32'(e_inta));
      chk("cmp_busy",    32'(busy),                    32'(e_busy));
      chk("cmp_valid",   32'(vector_valid),            32'(e_valid));
      chk("cmp_vtype",   32'(vector_type),             32'(e_vt));
      chk("cmp_caddr",   32'(call_address),            32'(e_ca));
      chk("cmp_err",     32'(call_opcode_error),       32'(e_err));
      chk("valid_inta_exclusive", 32'(vector_valid & ~interrupt_acknowledge_n), 32'd0);
    end
  end

  function automatic logic [7:0] pick(input int k, input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2);
    int p;
    p = k / P;
    if (p == 0) return b0;
    if (p == 1) return b1;
    return b2;
  endfunction

  // One acknowledge sequence: the first edge is the trigger edge.
  task automatic run_seq(input logic m, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input bit drop_int, input int exp_lat,
                         input logic [7:0] exp_vt, input logic [15:0] exp_ca,
                         input logic exp_err, input int hold);
    int lat;
    mode_8086 = m; int_request = 1'b1; cpu_int_enable = 1'b1; data_bus_in = b0;
    @(posedge clock); #1;
    if (drop_int) int_request = 1'b0;
    chk("inta_low_after_trigger", 32'(interrupt_acknowledge_n), 32'd0);
    chk("busy_after_trigger", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      data_bus_in = pick(k, b0, b1, b2);
      if (vector_valid) begin
        lat = k + 1;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("vector_type", 32'(vector_type), 32'(exp_vt));
    chk("call_address", 32'(call_address), 32'(exp_ca));
    chk("call_opcode_error", 32'(call_opcode_error), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      data_bus_in = 8'h5A ^ 8'(h);
      chk("hold_valid", 32'(vector_valid), 32'd1);
      chk("hold_vtype", 32'(vector_type), 32'(exp_vt));
      chk("hold_caddr", 32'(call_address), 32'(exp_ca));
    end
    vector_ready = 1'b1;
    @(posedge clock); #1;
    vector_ready = 1'b0;
    chk("valid_low_after_accept", 32'(vector_valid), 32'd0);
    chk("busy_low_after_accept", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    chk("rst_inta_n", 32'(interrupt_acknowledge_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(vector_valid), 32'd0);
    chk("rst_vtype", 32'(vector_type), 32'd0);
    chk("rst_caddr", 32'(call_address), 32'd0);
    chk("rst_err", 32'(call_opcode_error), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // 8086: dummy FF then vector 48.
    run_seq(1'b1, 8'hFF, 8'h48, 8'h00, 1'b1, 7, 8'h48, 16'h0000, 1'b0, 0);
    // 8080 CALL 1234, held 10 cycles, INT left high so the next one starts right away.
    run_seq(1'b0, 8'hCD, 8'h34, 8'h12, 1'b0, 11, 8'hCD, 16'h1234, 1'b0, 10);
    // Back-to-back 8080 with a bad opcode.
    run_seq(1'b0, 8'hC3, 8'h34, 8'h12, 1'b1, 11, 8'hC3, 16'h1234, 1'b1, 0);

    // IF=0 blocks the request.
    int_request = 1'b1; cpu_int_enable = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("if0_inta_n", 32'(interrupt_acknowledge_n), 32'd1);
    chk("if0_busy", 32'(busy), 32'd0);
    run_seq(1'b1, 8'h00, 8'h21, 8'h00, 1'b1, 7, 8'h21, 16'h0000, 1'b0, 2);

    // Reset during the second low pulse of an 8080 sequence.
    mode_8086 = 1'b0; int_request = 1'b1; cpu_int_enable = 1'b1; data_bus_in = 8'hCD;
    @(posedge clock); #1;
    int_request = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("second_pulse_low", 32'(interrupt_acknowledge_n), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_rst_inta_n", 32'(interrupt_acknowledge_n), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(vector_valid), 32'd0);
    chk("mid_rst_vtype", 32'(vector_type), 32'd0);
    chk("mid_rst_caddr", 32'(call_address), 32'd0);
    chk("mid_rst_err", 32'(call_opcode_error), 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      chk("no_valid_after_rst", 32'(vector_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
